prefetch_buffer: RTL and testbench



---
 rtl/prefetch_buffer.sv | 158 +++++++++++++++
 tb/tb_prefetch_buffer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: filters and queues ISB prefetches, issues them to memory
// one at a time, and serves demand lookups from a small associative buffer.
module prefetch_buffer #(
  parameter int DEPTH_LOG = 2,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prefetch_v,
  input  logic [AW-1:0] prefetch_addr,
  output logic          mem_req_v,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_resp_v,
  input  logic [DW-1:0] mem_resp_data,
  input  logic          demand_v,
  input  logic [AW-1:0] demand_addr,
  output logic          hit_v,
  output logic [DW-1:0] hit_data,
  output logic          demand_pending,
  output logic [7:0]    drop_cnt
);

  localparam int N = 1 << DEPTH_LOG;

  typedef enum logic [1:0] {
    E_INV, E_QUE, E_ISS, E_RDY
  } ent_t;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT
  } fsm_t;

  ent_t          st_q  [N];
  ent_t          st_d  [N];
  logic [AW-1:0] tag_q [N];
  logic [AW-1:0] tag_d [N];
  logic [DW-1:0] dat_q [N];
  logic [DW-1:0] dat_d [N];

  fsm_t                 fsm_q, fsm_d;
  logic [DEPTH_LOG-1:0] alloc_ptr, alloc_ptr_d;
  logic [DEPTH_LOG-1:0] issue_ptr, issue_ptr_d;
  logic                 req_v_d;
  logic [AW-1:0]        req_addr_d;

  logic          dup, alloc, drop;
  logic          hit_m, pend_m;
  logic [DW-1:0] hit_dat;

  // Probe all entries: duplicate filter, demand hit/pending, victim check.
  always_comb begin
    dup     = 1'b0;
    hit_m   = 1'b0;
    pend_m  = 1'b0;
    hit_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (st_q[i] != E_INV && tag_q[i] == prefetch_addr)
        dup = 1'b1;
      if (tag_q[i] == demand_addr) begin
        if (st_q[i] == E_RDY) begin
          hit_m   = 1'b1;
          hit_dat = dat_q[i];
        end
        if (st_q[i] == E_QUE || st_q[i] == E_ISS)
          pend_m = 1'b1;
      end
    end
    alloc = prefetch_v && !dup &&
            (st_q[alloc_ptr] == E_INV ||
             st_q[alloc_ptr] == E_RDY);
    drop  = prefetch_v && !dup && !alloc;
  end

  // Next entry state and issue FSM; allocation overrides a same-cycle hit.
  always_comb begin
    st_d        = st_q;
    tag_d       = tag_q;
    dat_d       = dat_q;
    fsm_d       = fsm_q;
    alloc_ptr_d = alloc_ptr;
    issue_ptr_d = issue_ptr;
    req_v_d     = mem_req_v;
    req_addr_d  = mem_req_addr;
    for (int i = 0; i < N; i++) begin
      if (demand_v && st_q[i] == E_RDY &&
          tag_q[i] == demand_addr)
        st_d[i] = E_INV;
    end
    if (alloc) begin
      st_d[alloc_ptr]  = E_QUE;
      tag_d[alloc_ptr] = prefetch_addr;
      alloc_ptr_d      = alloc_ptr + DEPTH_LOG'(1);
    end
    unique case (fsm_q)
      S_IDLE: begin
        if (st_q[issue_ptr] == E_QUE) begin
          fsm_d      = S_REQ;
          req_v_d    = 1'b1;
          req_addr_d = tag_q[issue_ptr];
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          fsm_d           = S_WAIT;
          req_v_d         = 1'b0;
          st_d[issue_ptr] = E_ISS;
        end
      end
      S_WAIT: begin
        if (mem_resp_v) begin
          fsm_d            = S_IDLE;
          st_d[issue_ptr]  = E_RDY;
          dat_d[issue_ptr] = mem_resp_data;
          issue_ptr_d      = issue_ptr + DEPTH_LOG'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers, request port and registered demand results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= E_INV;
        tag_q[i] <= '0;
        dat_q[i] <= '0;
      end
      fsm_q          <= S_IDLE;
      alloc_ptr      <= '0;
      issue_ptr      <= '0;
      mem_req_v      <= 1'b0;
      mem_req_addr   <= '0;
      hit_v          <= 1'b0;
      hit_data       <= '0;
      demand_pending <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      st_q           <= st_d;
      tag_q          <= tag_d;
      dat_q          <= dat_d;
      fsm_q          <= fsm_d;
      alloc_ptr      <= alloc_ptr_d;
      issue_ptr      <= issue_ptr_d;
      mem_req_v      <= req_v_d;
      mem_req_addr   <= req_addr_d;
      hit_v          <= demand_v && hit_m;
      demand_pending <= demand_v && pend_m;
      if (demand_v && hit_m)
        hit_data <= hit_dat;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: directed scenario tasks with hand-computed
// expectations for the prefetch buffer.
module tb_prefetch_buffer;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prefetch_v = 1'b0;
  logic [AW-1:0] prefetch_addr = '0;
  logic          mem_req_v;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_v = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;
  logic          demand_v = 1'b0;
  logic [AW-1:0] demand_addr = '0;
  logic          hit_v;
  logic [DW-1:0] hit_data;
  logic          demand_pending;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prefetch_buffer #(
    .DEPTH_LOG(2),
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prefetch_v(prefetch_v),
    .prefetch_addr(prefetch_addr),
    .mem_req_v(mem_req_v),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_v(mem_resp_v),
    .mem_resp_data(mem_resp_data),
    .demand_v(demand_v),
    .demand_addr(demand_addr),
    .hit_v(hit_v),
    .hit_data(hit_data),
    .demand_pending(demand_pending),
    .drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    prefetch_v = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_v = 1'b0;
    demand_v = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // wait (bounded) for a request, accept it, then return data
  task automatic serve(input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int c;
    c = 0;
    while (mem_req_v !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    total++;
    if (mem_req_v !== 1'b1 || mem_req_addr !== a) begin
      bad++;
      $display("FAIL serve_req v=%b addr=%h want v=1 addr=%h",
               mem_req_v, mem_req_addr, a);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_resp_v = 1'b1;
    mem_resp_data = d;
    tick();
    mem_resp_v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({mem_req_v, hit_v, demand_pending} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {mem_req_v, hit_v, demand_pending});
    end
    total++;
    if (mem_req_addr !== 16'h0 || hit_data !== 16'h0 ||
        drop_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset_vals addr=%h data=%h drop=%h want 0",
               mem_req_addr, hit_data, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    mem_req_ready = 1'b1;
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0040;
    tick();
    prefetch_v = 1'b0;
    total++;
    if (mem_req_v !== 1'b0) begin
      bad++;
      $display("FAIL basic_early got=%b want=0", mem_req_v);
    end
    tick();
    total++;
    if (mem_req_v !== 1'b1 || mem_req_addr !== 16'h0040) begin
      bad++;
      $display("FAIL basic_req v=%b addr=%h want 1/0040",
               mem_req_v, mem_req_addr);
    end
    tick();
    total++;
    if (mem_req_v !== 1'b0) begin
      bad++;
      $display("FAIL basic_accept got=%b want=0", mem_req_v);
    end
    tick();
    mem_resp_v = 1'b1;
    mem_resp_data = 16'hBEEF;
    tick();
    mem_resp_v = 1'b0;
    demand_v = 1'b1;
    demand_addr = 16'h0040;
    tick();
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'hBEEF ||
        demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL basic_hit hit=%b data=%h pend=%b want 1/BEEF/0",
               hit_v, hit_data, demand_pending);
    end
    tick();
    total++;
    if (hit_v !== 1'b0 || demand_pending !== 1'b0 ||
        hit_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL basic_miss hit=%b pend=%b data=%h want 0/0/BEEF",
               hit_v, demand_pending, hit_data);
    end
    demand_v = 1'b0;
  endtask

  task automatic test_dup();
    int reqs;
    do_reset();
    mem_req_ready = 1'b1;
    mem_resp_data = 16'h1010;
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0010;
    reqs = 0;
    tick();
    if (mem_req_v === 1'b1) reqs++;
    tick();
    if (mem_req_v === 1'b1) reqs++;
    prefetch_v = 1'b0;
    mem_resp_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req_v === 1'b1) reqs++;
    end
    mem_resp_v = 1'b0;
    total++;
    if (reqs != 1) begin
      bad++;
      $display("FAIL dup_reqs got=%0d want=1", reqs);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL dup_drop got=%0d want=0", drop_cnt);
    end
    demand_v = 1'b1;
    demand_addr = 16'h0010;
    tick();
    demand_v = 1'b0;
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'h1010) begin
      bad++;
      $display("FAIL dup_hit hit=%b data=%h want 1/1010",
               hit_v, hit_data);
    end
  endtask

  task automatic test_full();
    int badreq;
    do_reset();
    mem_req_ready = 1'b0;
    badreq = 0;
    prefetch_v = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      prefetch_addr = AW'(i);
      tick();
      if (i >= 2 && (mem_req_v !== 1'b1 ||
                     mem_req_addr !== 16'h0001))
        badreq++;
      if (i == 4) begin
        total++;
        if (drop_cnt !== 8'd0) begin
          bad++;
          $display("FAIL full_nodrop got=%0d want=0", drop_cnt);
        end
      end
    end
    prefetch_v = 1'b0;
    total++;
    if (drop_cnt !== 8'd1) begin
      bad++;
      $display("FAIL full_drop got=%0d want=1", drop_cnt);
    end
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0006;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (mem_req_v !== 1'b1 || mem_req_addr !== 16'h0001)
        badreq++;
    end
    prefetch_v = 1'b0;
    total++;
    if (badreq != 0) begin
      bad++;
      $display("FAIL full_hold got=%0d bad cycles want=0", badreq);
    end
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_sat got=%0d want=255", drop_cnt);
    end
  endtask

  task automatic test_pending();
    do_reset();
    mem_req_ready = 1'b1;
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0020;
    tick();
    prefetch_v = 1'b0;
    tick();
    tick();
    demand_v = 1'b1;
    demand_addr = 16'h0020;
    tick();
    total++;
    if (demand_pending !== 1'b1 || hit_v !== 1'b0) begin
      bad++;
      $display("FAIL pend_issued pend=%b hit=%b want 1/0",
               demand_pending, hit_v);
    end
    mem_resp_v = 1'b1;
    mem_resp_data = 16'h2222;
    tick();
    mem_resp_v = 1'b0;
    total++;
    if (demand_pending !== 1'b1 || hit_v !== 1'b0) begin
      bad++;
      $display("FAIL pend_resp pend=%b hit=%b want 1/0",
               demand_pending, hit_v);
    end
    tick();
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'h2222 ||
        demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL pend_hit hit=%b data=%h pend=%b want 1/2222/0",
               hit_v, hit_data, demand_pending);
    end
    demand_v = 1'b0;
    tick();
    total++;
    if (hit_v !== 1'b0 || demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL pend_idle hit=%b pend=%b want 0/0",
               hit_v, demand_pending);
    end
  endtask

  task automatic test_victim();
    logic [AW-1:0] a;
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0100 + AW'(i);
      prefetch_v = 1'b1;
      prefetch_addr = a;
      tick();
      prefetch_v = 1'b0;
      serve(a, 16'hA100 + DW'(i));
    end
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0200;
    demand_v = 1'b1;
    demand_addr = 16'h0100;
    tick();
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'hA100) begin
      bad++;
      $display("FAIL victim_hit hit=%b data=%h want 1/A100",
               hit_v, hit_data);
    end
    prefetch_addr = 16'h0102;
    demand_addr = 16'h0102;
    tick();
    prefetch_v = 1'b0;
    total++;
    if (mem_req_v !== 1'b1 || mem_req_addr !== 16'h0200) begin
      bad++;
      $display("FAIL victim_req v=%b addr=%h want 1/0200",
               mem_req_v, mem_req_addr);
    end
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'hA102 ||
        drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL dup_inval hit=%b data=%h drop=%0d want 1/A102/0",
               hit_v, hit_data, drop_cnt);
    end
    tick();
    total++;
    if (hit_v !== 1'b0 || demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL dup_inval_miss hit=%b pend=%b want 0/0",
               hit_v, demand_pending);
    end
    demand_addr = 16'h0101;
    tick();
    total++;
    if (hit_v !== 1'b1 || hit_data !== 16'hA101) begin
      bad++;
      $display("FAIL victim_keep hit=%b data=%h want 1/A101",
               hit_v, hit_data);
    end
    demand_addr = 16'h0200;
    tick();
    demand_v = 1'b0;
    total++;
    if (demand_pending !== 1'b1 || hit_v !== 1'b0) begin
      bad++;
      $display("FAIL victim_pend pend=%b hit=%b want 1/0",
               demand_pending, hit_v);
    end
  endtask

  task automatic test_reset_mid();
    int spur;
    do_reset();
    mem_req_ready = 1'b1;
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0300;
    tick();
    prefetch_v = 1'b0;
    serve(16'h0300, 16'h3333);
    demand_v = 1'b1;
    demand_addr = 16'h0300;
    tick();
    demand_v = 1'b0;
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0301;
    tick();
    prefetch_v = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    total++;
    if (mem_req_v !== 1'b0 || hit_data !== 16'h0 ||
        hit_v !== 1'b0 || drop_cnt !== 8'h0 ||
        mem_req_addr !== 16'h0 || demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset v=%b addr=%h data=%h hit=%b want 0s",
               mem_req_v, mem_req_addr, hit_data, hit_v);
    end
    tick();
    rst = 1'b0;
    mem_resp_v = 1'b1;
    mem_resp_data = 16'hDEAD;
    tick();
    mem_resp_v = 1'b0;
    demand_v = 1'b1;
    demand_addr = 16'h0301;
    spur = 0;
    tick();
    demand_v = 1'b0;
    total++;
    if (hit_v !== 1'b0 || demand_pending !== 1'b0) begin
      bad++;
      $display("FAIL mid_stale hit=%b pend=%b want 0/0",
               hit_v, demand_pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_req_v !== 1'b0) spur++;
    end
    total++;
    if (spur != 0) begin
      bad++;
      $display("FAIL mid_spurious got=%0d want=0", spur);
    end
    prefetch_v = 1'b1;
    prefetch_addr = 16'h0400;
    tick();
    prefetch_v = 1'b0;
    tick();
    total++;
    if (mem_req_v !== 1'b1 || mem_req_addr !== 16'h0400) begin
      bad++;
      $display("FAIL mid_restart v=%b addr=%h want 1/0400",
               mem_req_v, mem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_full();
    test_pending();
    test_victim();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
